alu_decode_exec: RTL
====================

Name: alu_decode_exec

Overview:
- Parametrised successor to the 3-bit ALU control decoder. It decodes ALUOp/op/funct3/funct7 into a full 4-bit RV32I+M ALU control and executes the operation.
- Base ops complete with a registered 1-cycle latency. MUL/MULHU/DIV/DIVU/REM/REMU run on an iterative sequencer that stalls issue through a valid/ready handshake.
- Sits between the control unit/register file and writeback. It is the first multi-cycle execute block in the core.

Parameters:
- XLEN, 32, datapath width; power of two, >= 8.
- ENABLE_M, 1, 1 = M-subset ops executed; 0 = M encodings flagged illegal.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept; transfer when in_valid & in_ready.
- ALUOp  in  2  00 = add, 01 = sub, 10 = decode funct fields, 11 = reserved.
- op  in  7  instruction opcode; only op[5] (R-type) is used.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- src_a  in  XLEN  operand A (rs1).
- src_b  in  XLEN  operand B (rs2 or immediate).
- out_valid  out  1  one-cycle pulse: result/alu_ctrl/illegal valid.
- result  out  XLEN  operation result.
- alu_ctrl  out  4  decoded control of the completed op.
- illegal  out  1  completed op was an unsupported encoding.

Behaviour:
- Reset values: in_ready = 1, out_valid = 0, result = 0, alu_ctrl = 0, illegal = 0. Sequencer returns to IDLE.
- Reset mid-operation: the op is aborted and never produces out_valid. The block accepts again on the first cycle after rst deasserts.
- Control codes (low three bits are legacy-compatible):
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLL 0110, SRL 0111
  - SRA 1000, SLTU 1001, MUL 1010, MULHU 1011, DIV 1100, DIVU 1101, REM 1110, REMU 1111
- Decode rules:
  - ALUOp 00 -> ADD; ALUOp 01 -> SUB.
  - ALUOp 10 with op[5]=1 and funct7=0000001 -> M group by funct3:
    - 000 MUL, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
    - 001/010 -> illegal.
    - All M codes are illegal when ENABLE_M=0.
  - Otherwise ALUOp 10 decodes by funct3:
    - 000: SUB if op[5]&funct7[5], else ADD.
    - 001 SLL; 010 SLT; 011 SLTU; 100 XOR.
    - 101: SRA if funct7[5], else SRL.
    - 110 OR; 111 AND.
  - ALUOp 11 -> illegal.
- Illegal ops: 1-cycle latency, result = 0, alu_ctrl = ADD, illegal = 1.
- Arithmetic rules:
  - Shift amount = src_b[log2(XLEN)-1:0].
  - SLT is signed; SLTU is unsigned; both yield a 0/1 result.
  - ADD/SUB wrap modulo 2^XLEN.
  - MUL = low XLEN bits of the product; MULHU = high XLEN bits of the unsigned product.
  - DIV/REM are signed with quotient truncated toward zero; the remainder takes the dividend's sign.
- Divide boundary cases:
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (DIV/REM of -2^(XLEN-1) by -1): quotient = -2^(XLEN-1), remainder = 0.
  - Both cases complete with normal M latency; no fast path.
- Timing, base/illegal ops:
  - Accepted at edge N; out_valid = 1 on cycle N+1.
  - in_ready stays 1, so back-to-back issue gives one result per cycle.
- Timing, M ops:
  - State machine IDLE -> BUSY (counter XLEN-1 down to 0, one shift-add or restoring-subtract step per cycle) -> IDLE.
  - in_ready = 0 from cycle N+1 until out_valid.
  - out_valid on cycle N+XLEN+1. in_ready returns to 1 in that same cycle, so a new op may be accepted there.
- Input capture: inputs are sampled only on accept. Changes while busy are ignored; in_valid while in_ready = 0 is not accepted.
- Output hold: result/alu_ctrl/illegal hold their last values while out_valid = 0.
- No output backpressure: downstream must consume out_valid in the cycle it is asserted.

Decomposition:
- Package alu_pkg holds:
  - the 4-bit ALU control code constants;
  - ALUOp constants;
  - funct7 constants (0000000, 0100000, 0000001).
- Sub-module muldiv_iter (XLEN parameter) owns the iterative multiply/divide datapath, counter, sign fix-up and divide special cases. Its interface:
  - inputs start, ctrl, a, b;
  - outputs done, res.
- The top level holds the decoder, the base ALU, the handshake and the output registers.

Test Plan:
- rst held 3 cycles, then released, XLEN=32 -> in_ready = 1, out_valid = 0, result = 0 throughout and after release.
- Back-to-back base ops, ALUOp=10:
  - op[5]=1, funct7=0100000, funct3=000, a=5, b=7 -> SUB, result FFFFFFFE.
  - funct3=101, funct7=0100000, a=80000000, b=4 -> SRA, result F8000000.
  - funct3=011, a=FFFFFFFF, b=1 -> SLTU, result 0.
  - Each result arrives 1 cycle after accept, with no in_ready drop.
- MUL a=0001_0000, b=0001_0000 -> result 0, alu_ctrl 1010. Same operands with MULHU -> result 1.
  - out_valid exactly 33 cycles after accept; in_ready = 0 in between.
  - in_valid held high the whole time is not accepted until the out_valid cycle.
- Divide special cases:
  - DIV a=80000000, b=FFFFFFFF -> 80000000; REM with same operands -> 0.
  - DIVU a=7, b=0 -> FFFFFFFF; REMU a=7, b=0 -> 7.
  - DIV a=-7, b=2 -> FFFFFFFD; REM a=-7, b=2 -> FFFFFFFF.
- rst asserted 10 cycles into a DIVU -> no out_valid for that op; in_ready = 1 the cycle after release; a subsequent ADD 2+3 returns 5.
- ENABLE_M=0: MUL encoding -> illegal = 1, result 0, latency 1. ALUOp=11 -> illegal = 1 for any ENABLE_M.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared encodings for the decode/execute ALU: 4-bit ALU
//               control codes (low three bits match the legacy 3-bit
//               decoder), ALUOp values, funct7 values and a helper that
//               identifies control codes routed to the iterative M unit.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU control codes
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLL   = 4'b0110;
  localparam logic [3:0] ALU_SRL   = 4'b0111;
  localparam logic [3:0] ALU_SRA   = 4'b1000;
  localparam logic [3:0] ALU_SLTU  = 4'b1001;
  localparam logic [3:0] ALU_MUL   = 4'b1010;
  localparam logic [3:0] ALU_MULHU = 4'b1011;
  localparam logic [3:0] ALU_DIV   = 4'b1100;
  localparam logic [3:0] ALU_DIVU  = 4'b1101;
  localparam logic [3:0] ALU_REM   = 4'b1110;
  localparam logic [3:0] ALU_REMU  = 4'b1111;

  // ALUOp from the control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  // funct7 values
  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Codes 1010..1111 are the multi-cycle multiply/divide group.
  function automatic logic is_muldiv(input logic [3:0] ctrl);
    return ctrl[3] & (ctrl[2] | ctrl[1]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decode_exec_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : Iterative unsigned shift-add multiplier / restoring divider
//               with sign fix-up for DIV/REM and divide-by-zero handling.
//               One step per cycle for XLEN cycles after start.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               start     - begin an op (only honoured while idle)
//               ctrl      - 4-bit ALU control (MUL..REMU)
//               a, b      - operands, captured on start
//               done      - high in the final step cycle; res valid then
//               res       - result, combinational, meaningful with done
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] hi, lo, m, dividend;
  logic [XLEN-1:0] hi_nxt, lo_nxt;
  logic [3:0]      op_q;
  logic            neg_q, neg_r, div0;

  logic            sgn, ld_mul, is_mul_q;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   sum, shifted, diff;

  assign sgn      = (ctrl == ALU_DIV) || (ctrl == ALU_REM);
  assign ld_mul   = (ctrl == ALU_MUL) || (ctrl == ALU_MULHU);
  assign is_mul_q = (op_q == ALU_MUL) || (op_q == ALU_MULHU);
  assign a_mag    = (sgn && a[XLEN-1]) ? -a : a;
  assign b_mag    = (sgn && b[XLEN-1]) ? -b : b;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign done = (state == BUSY) && (cnt == '0);

  // One iteration. Multiply: {hi,lo} is the product/multiplier pair shifted
  // right each step. Divide: hi is the partial remainder, lo shifts the
  // dividend out at the top and the quotient in at the bottom.
  always_comb begin
    sum     = {1'b0, hi} + {1'b0, m};
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, m};
    hi_nxt  = hi;
    lo_nxt  = lo;
    if (is_mul_q) begin
      if (lo[0]) {hi_nxt, lo_nxt} = {sum, lo[XLEN-1:1]};
      else       {hi_nxt, lo_nxt} = {1'b0, hi, lo[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      hi_nxt = diff[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], 1'b1};
    end else begin
      hi_nxt = shifted[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], 1'b0};
    end
  end

  // Final result from the last step. Signed overflow (-2^(XLEN-1) / -1)
  // needs no special case: magnitude quotient 2^(XLEN-1) with no negation.
  always_comb begin
    res = '0;
    case (op_q)
      ALU_MUL:           res = lo_nxt;
      ALU_MULHU:         res = hi_nxt;
      ALU_DIV, ALU_DIVU: res = div0 ? '1 : (neg_q ? -lo_nxt : lo_nxt);
      ALU_REM, ALU_REMU: res = div0 ? dividend : (neg_r ? -hi_nxt : hi_nxt);
      default:           res = '0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      m        <= '0;
      dividend <= '0;
      op_q     <= ALU_ADD;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0     <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt      <= CW'(XLEN - 1);
      hi       <= '0;
      lo       <= ld_mul ? b : a_mag;
      m        <= ld_mul ? a : b_mag;
      dividend <= a;
      op_q     <= ctrl;
      neg_q    <= sgn & (a[XLEN-1] ^ b[XLEN-1]);
      neg_r    <= sgn & a[XLEN-1];
      div0     <= (b == '0);
    end else if (state == BUSY) begin
      cnt <= cnt - 1'b1;
      hi  <= hi_nxt;
      lo  <= lo_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_decode_exec.sv
`default_nettype none
// ============================================================================
// Module      : alu_decode_exec
// Description : Decodes ALUOp/op/funct3/funct7 into a 4-bit RV32I+M ALU
//               control and executes it. Base/illegal ops: one-cycle
//               registered latency. M ops: iterative, XLEN+1 cycles, issue
//               stalled via in_ready.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               in_valid/in_ready - issue handshake
//               ALUOp, op, funct3, funct7 - decode inputs (op[5] only)
//               src_a, src_b      - operands
//               out_valid         - one-cycle completion pulse
//               result, alu_ctrl, illegal - completed op, held otherwise
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decode_exec
  import alu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic [3:0]      alu_ctrl,
  output logic            illegal
);

  localparam int SHW = $clog2(XLEN);

  logic [3:0]      dec_ctrl;
  logic            dec_illegal;
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;
  logic            accept, start;
  logic            m_busy, m_done;
  logic [3:0]      m_ctrl;
  logic [XLEN-1:0] m_res;
  logic            unused_op;

  assign unused_op = ^{op[6], op[4:0]};

  // Decoder; illegal encodings always report ADD.
  always_comb begin
    dec_ctrl    = ALU_ADD;
    dec_illegal = 1'b0;
    case (ALUOp)
      ALUOP_ADD: dec_ctrl = ALU_ADD;
      ALUOP_SUB: dec_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        if (op[5] && funct7 == FUNCT7_MULDIV) begin
          case (funct3)
            3'b000:  dec_ctrl = ALU_MUL;
            3'b011:  dec_ctrl = ALU_MULHU;
            3'b100:  dec_ctrl = ALU_DIV;
            3'b101:  dec_ctrl = ALU_DIVU;
            3'b110:  dec_ctrl = ALU_REM;
            3'b111:  dec_ctrl = ALU_REMU;
            default: dec_illegal = 1'b1;
          endcase
          if (!ENABLE_M) dec_illegal = 1'b1;
        end else begin
          case (funct3)
            3'b000:  dec_ctrl = (op[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  dec_ctrl = ALU_SLL;
            3'b010:  dec_ctrl = ALU_SLT;
            3'b011:  dec_ctrl = ALU_SLTU;
            3'b100:  dec_ctrl = ALU_XOR;
            3'b101:  dec_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  dec_ctrl = ALU_OR;
            default: dec_ctrl = ALU_AND;
          endcase
        end
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) dec_ctrl = ALU_ADD;
  end

  // Single-cycle base ALU
  assign shamt = src_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (dec_ctrl)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_SLL:  alu_res = src_a << shamt;
      ALU_SRL:  alu_res = src_a >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  // Handshake: only the M unit ever stalls issue.
  assign in_ready = !m_busy;
  assign accept   = in_valid && in_ready;
  assign start    = accept && !dec_illegal && is_muldiv(dec_ctrl);

  muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .ctrl  (dec_ctrl),
    .a     (src_a),
    .b     (src_b),
    .done  (m_done),
    .res   (m_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_ctrl <= ALU_ADD;
    end else if (start) begin
      m_busy <= 1'b1;
      m_ctrl <= dec_ctrl;
    end else if (m_done) begin
      m_busy <= 1'b0;
    end
  end

  // Output registers; m_done and accept are mutually exclusive (busy vs idle).
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      alu_ctrl  <= ALU_ADD;
      illegal   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (m_done) begin
        out_valid <= 1'b1;
        result    <= m_res;
        alu_ctrl  <= m_ctrl;
        illegal   <= 1'b0;
      end else if (accept && !start) begin
        out_valid <= 1'b1;
        result    <= dec_illegal ? '0 : alu_res;
        alu_ctrl  <= dec_ctrl;
        illegal   <= dec_illegal;
      end
    end
  end

endmodule
`default_nettype wire
